sine_period_meter: RTL and testbench

SINE_PERIOD_METER -- requirements
Module: sine_period_meter

---
 rtl/wave_meas_pkg.sv | 15 +
 rtl/wave_level_detector.sv | 41 ++++
 rtl/sine_period_meter.sv | 145 ++++++++++++++
 tb/tb_sine_period_meter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_meas_pkg.sv
// rtl/wave_meas_pkg.sv - shared widths, default thresholds and FSM encoding for the wave meter
package wave_meas_pkg;

  localparam int SAMPLE_W     = 8;
  localparam int PERIOD_W     = 16;
  localparam int DEF_MIDPOINT = 128;
  localparam int DEF_HYST     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_MEASURE = 2'd2
  } meas_state_t;

endpackage

// File: rtl/wave_level_detector.sv
// rtl/wave_level_detector.sv - hysteresis level tracker producing a rising-crossing pulse
module wave_level_detector
  import wave_meas_pkg::*;
#(
  parameter int MIDPOINT = DEF_MIDPOINT,
  parameter int HYST     = DEF_HYST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                valid,
  input  logic                clear,
  output logic                rise_pulse
);

  logic level_high;
  logic above_hi;
  logic below_lo;

  assign above_hi = int'(sample) >= (MIDPOINT + HYST);
  assign below_lo = int'(sample) <= (MIDPOINT - HYST);

  // Combinational so the crossing is acted on by the same edge that accepts the sample.
  assign rise_pulse = valid && !level_high && above_hi;

  // Level starts HIGH after reset or clear so a genuine low excursion is needed before a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_high <= 1'b1;
    end else if (clear) begin
      level_high <= 1'b1;
    end else if (valid) begin
      if (above_hi) begin
        level_high <= 1'b1;
      end else if (below_lo) begin
        level_high <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sine_period_meter.sv
// rtl/sine_period_meter.sv - measures period and peak levels of a sampled periodic waveform
module sine_period_meter
  import wave_meas_pkg::*;
#(
  parameter int MIDPOINT    = DEF_MIDPOINT,
  parameter int HYST        = DEF_HYST,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [PERIOD_W-1:0] period,
  output logic [SAMPLE_W-1:0] peak_max,
  output logic [SAMPLE_W-1:0] peak_min,
  output logic [SAMPLE_W-1:0] amplitude,
  output logic                result_valid,
  output logic                signal_lost
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT_CYC);
  localparam logic [PERIOD_W-1:0] CNT_MAX     = '1;

  meas_state_t         state, state_nxt;
  logic [PERIOD_W-1:0] cycle_cnt;
  logic [SAMPLE_W-1:0] run_max, run_min;
  logic [SAMPLE_W-1:0] new_max, new_min;
  logic                rise;
  logic                clear_level;
  logic                sync_cross;
  logic                meas_cross;
  logic                timeout;

  wave_level_detector #(
    .MIDPOINT (MIDPOINT),
    .HYST     (HYST)
  ) u_level (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample_in),
    .valid      (sample_valid),
    .clear      (clear_level),
    .rise_pulse (rise)
  );

  // Tracker is held HIGH while idle and re-armed HIGH when a timeout drops back to SYNC.
  assign clear_level = (state == ST_IDLE) || timeout;

  // Running extremes folded with the current sample; the crossing sample belongs to the closing period.
  assign new_max = (sample_in > run_max) ? sample_in : run_max;
  assign new_min = (sample_in < run_min) ? sample_in : run_min;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-edge events; a crossing wins over a coincident timeout.
  always_comb begin
    state_nxt  = state;
    sync_cross = 1'b0;
    meas_cross = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (rise) begin
          state_nxt  = ST_MEASURE;
          sync_cross = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (rise) begin
          meas_cross = 1'b1;
        end else if (cycle_cnt >= TIMEOUT_CNT) begin
          timeout   = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Edge counter: starts at 1 on a crossing, saturates, and rests at 0 outside MEASURE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (sync_cross || meas_cross) begin
      cycle_cnt <= PERIOD_W'(1);
    end else if (state == ST_MEASURE && state_nxt == ST_MEASURE) begin
      if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + PERIOD_W'(1);
    end else begin
      cycle_cnt <= '0;
    end
  end

  // Running max/min restart from the crossing sample and absorb every accepted sample while measuring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_max <= '0;
      run_min <= '1;
    end else if (sync_cross || meas_cross) begin
      run_max <= sample_in;
      run_min <= sample_in;
    end else if (state == ST_MEASURE && sample_valid) begin
      run_max <= new_max;
      run_min <= new_min;
    end
  end

  // Result registers update only on a completed period and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period       <= '0;
      peak_max     <= '0;
      peak_min     <= '0;
      amplitude    <= '0;
      result_valid <= 1'b0;
      signal_lost  <= 1'b0;
    end else begin
      result_valid <= meas_cross;
      if (meas_cross) begin
        period      <= cycle_cnt;
        peak_max    <= new_max;
        peak_min    <= new_min;
        amplitude   <= new_max - new_min;
        signal_lost <= 1'b0;
      end else if (timeout) begin
        signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sine_period_meter.sv
// tb/tb_sine_period_meter.sv - randomized scoreboard bench for sine_period_meter
module tb_sine_period_meter;
  import wave_meas_pkg::*;

  localparam int MID = 128;
  localparam int HY  = 8;
  localparam int TO  = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [7:0]  sample_in;
  logic [15:0] period;
  logic [7:0]  peak_max, peak_min, amplitude;
  logic        result_valid, signal_lost;

  sine_period_meter #(
    .MIDPOINT    (MID),
    .HYST        (HY),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .period       (period),
    .peak_max     (peak_max),
    .peak_min     (peak_min),
    .amplitude    (amplitude),
    .result_valid (result_valid),
    .signal_lost  (signal_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int mx;
    int mn;
    int amp;
  } res_t;

  res_t exp_q[$];
  res_t held;
  int   total = 0;
  int   bad = 0;
  int   pulses_seen = 0;
  int   pulses_exp = 0;

  // Reference model: mode 0 idle, 1 waiting for first rise, 2 measuring.
  int   m_mode;
  bit   m_level;
  int   m_n;
  int   m_last;
  int   m_win[$];
  bit   exp_lost;
  bit   exp_pulse;

  int   sine_tab[64];
  int   ph_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode    = 0;
    m_level   = 1'b1;
    m_last    = 0;
    m_win.delete();
    exp_q.delete();
    exp_lost  = 1'b0;
    exp_pulse = 1'b0;
    held      = '{0, 0, 0, 0};
  endfunction

  // Predicts what the DUT shows after the coming clock edge for these inputs.
  function automatic void model_step(input bit en, input bit v, input int s);
    bit   rise;
    int   mx, mn, gap;
    res_t r;
    m_n++;
    exp_pulse = 1'b0;
    rise = v && !m_level && (s >= MID + HY);
    if (!en || m_mode == 0) begin
      m_mode  = en ? 1 : 0;
      m_level = 1'b1;
      return;
    end
    if (v) begin
      if (s >= MID + HY) m_level = 1'b1;
      else if (s <= MID - HY) m_level = 1'b0;
    end
    if (m_mode == 1) begin
      if (rise) begin
        m_mode = 2;
        m_last = m_n;
        m_win.delete();
        m_win.push_back(s);
      end
    end else begin
      if (v) m_win.push_back(s);
      gap = m_n - m_last;
      if (gap > 65535) gap = 65535;
      if (rise) begin
        mx = 0;
        mn = 255;
        foreach (m_win[i]) begin
          if (m_win[i] > mx) mx = m_win[i];
          if (m_win[i] < mn) mn = m_win[i];
        end
        r = '{gap, mx, mn, mx - mn};
        exp_q.push_back(r);
        pulses_exp++;
        exp_pulse = 1'b1;
        exp_lost  = 1'b0;
        m_last = m_n;
        m_win.delete();
        m_win.push_back(s);
      end else if (gap >= TO) begin
        exp_lost = 1'b1;
        m_mode   = 1;
        m_level  = 1'b1;
      end
    end
  endfunction

  task automatic drive(input bit en, input bit v, input int s);
    @(negedge clk);
    enable       = en;
    sample_valid = v;
    sample_in    = s[7:0];
    model_step(en, v, s);
  endtask

  task automatic run_tab(input int n, input int vevery);
    bit v;
    for (int c = 0; c < n; c++) begin
      v = (c % vevery) == 0;
      if (v) begin
        drive(1'b1, 1'b1, sine_tab[ph_g % 64]);
        ph_g++;
      end else begin
        drive(1'b1, 1'b0, int'($urandom_range(0, 255)));
      end
    end
  endtask

  task automatic run_rand(input int p, input int a, input int dens, input int n);
    bit  v;
    real x;
    int  s;
    for (int c = 0; c < n; c++) begin
      v = $urandom_range(0, 99) < dens;
      if (v) begin
        x = 128.0 + a * $sin(2.0 * 3.14159265358979 * ph_g / p);
        s = $rtoi(x + 0.5);
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        ph_g++;
        drive(1'b1, 1'b1, s);
      end else begin
        drive(1'b1, 1'b0, int'($urandom_range(0, 255)));
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset        = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 8'd0;
    model_step(1'b0, 1'b0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_peak_max"}, peak_max, 0);
    check({tag, "_peak_min"}, peak_min, 0);
    check({tag, "_amplitude"}, amplitude, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_signal_lost"}, signal_lost, 0);
  endtask

  task automatic check_result(input string tag, input int per, input int mx, input int mn);
    check({tag, "_period"}, period, per);
    check({tag, "_peak_max"}, peak_max, mx);
    check({tag, "_peak_min"}, peak_min, mn);
    check({tag, "_amplitude"}, amplitude, mx - mn);
  endtask

  // Monitor: pops the scoreboard on each pulse, otherwise requires the outputs to hold.
  initial begin
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      check("result_valid", result_valid, exp_pulse);
      check("signal_lost", signal_lost, exp_lost);
      if (result_valid === 1'b1) begin
        pulses_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse actual=1 required=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_period", period, e.per);
          check("sb_peak_max", peak_max, e.mx);
          check("sb_peak_min", peak_min, e.mn);
          check("sb_amplitude", amplitude, e.amp);
          held = e;
        end
      end else begin
        check("hold_period", period, held.per);
        check("hold_peak_max", peak_max, held.mx);
        check("hold_peak_min", peak_min, held.mn);
        check("hold_amplitude", amplitude, held.amp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 8'd0;
    m_n          = 0;
    ph_g         = 0;
    model_reset();
    for (int k = 0; k < 64; k++)
      sine_tab[k] = $rtoi(137.0 + 108.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5);

    repeat (3) @(negedge clk);
    check_zero("reset");
    release_reset();

    // Full-rate sine.
    ph_g = 0;
    run_tab(64 * 10, 1);
    check_result("full_rate", 64, 245, 29);

    // Same sine, one accepted sample every fourth clock.
    ph_g = 0;
    run_tab(256 * 5, 4);
    check_result("quarter_rate", 256, 245, 29);

    // Small noise around the midpoint never crosses the hysteresis band.
    for (int c = 0; c < TO + 300; c++)
      drive(1'b1, 1'b1, 128 + int'($urandom_range(0, 10)) - 5);
    check("noise_signal_lost", signal_lost, 1);
    check("noise_state_sync", dut.state, ST_SYNC);
    check_result("noise_hold", 256, 245, 29);

    // Signal returns.
    ph_g = 0;
    run_tab(64 * 4, 1);
    check("restore_signal_lost", signal_lost, 0);
    check_result("restore", 64, 245, 29);

    // Enable dropped 20 cycles into a period, then re-raised.
    run_tab(20, 1);
    for (int c = 0; c < 10; c++) drive(1'b0, 1'b1, sine_tab[(ph_g + c) % 64]);
    check_result("enable_drop_hold", 64, 245, 29);
    run_tab(64 * 4, 1);
    check_result("enable_resync", 64, 245, 29);

    // Randomized sines: period, amplitude and valid density all vary.
    for (int r = 0; r < 3; r++) begin
      ph_g = 0;
      run_rand(int'($urandom_range(30, 90)), int'($urandom_range(30, 120)),
               int'($urandom_range(50, 100)), 600);
    end

    // Asynchronous reset mid-period.
    ph_g = 0;
    run_tab(64 * 2 + 30, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_zero("async_reset");
    release_reset();
    ph_g = 0;
    run_tab(64 * 3, 1);
    check_result("after_reset", 64, 245, 29);

    repeat (3) drive(1'b0, 1'b0, 0);
    @(posedge clk);
    #2;
    check("queue_empty", exp_q.size(), 0);
    check("pulse_count", pulses_seen, pulses_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
